keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/key_fifo.sv | 63 ++++++
 rtl/keypad_scanner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: scan state encodings, event polarity constants and the key-code
// width helper shared by the keypad scanner and its event queue.
package keypad_pkg;

  typedef logic [1:0] scan_state_t;

  localparam scan_state_t ST_DWELL   = 2'd0;
  localparam scan_state_t ST_SAMPLE  = 2'd1;
  localparam scan_state_t ST_EMIT    = 2'd2;
  localparam scan_state_t ST_ADVANCE = 2'd3;

  localparam logic EV_PRESS   = 1'b0;
  localparam logic EV_RELEASE = 1'b1;

  // Bits needed to number every key of a rows x cols matrix.
  function automatic int key_width(input int rows, input int cols);
    int n;
    n = rows * cols;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small synchronous event queue. The head entry is visible
// combinationally; a push into a full queue is accepted only when a pop
// frees a slot in the same cycle.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage values for one push and/or one pop per cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Queue registers; reset empties the queue and clears stale entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans an active-low key matrix one column at a time,
// debounces every key independently and queues press/release events.
// Optional feature macro: KEYPAD_REPEAT_EN adds auto-repeat press events
// for keys held down (REPEAT_DELAY scans to the first repeat, then every
// REPEAT_RATE scans).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 8192,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8,
`endif
  localparam int KEY_W         = key_width(ROWS, COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  column,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KEY_W-1:0] key_code,
  output logic             key_release,
  output logic             overflow
);

  localparam int NKEYS      = ROWS * COLS;
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW         = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW         = $clog2(SCAN_DIV);
  localparam int DWELL_LAST = SCAN_DIV - ROWS - 3;

  scan_state_t     state_q, state_d;
  logic [DW-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [ROWS-1:0] raw_q, raw_d;
  logic [NKEYS-1:0] stable_q, stable_d;
  logic [3:0]      deb_cnt_q [NKEYS];
  logic [3:0]      deb_cnt_d [NKEYS];
  logic            overflow_q, overflow_d;

  logic [KEY_W-1:0] key_idx;
  logic             cur_raw;
  logic             toggle;
  logic             ev_push;
  logic [KEY_W:0]   ev_data;
  logic             ev_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [KEY_W:0]   fifo_head;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q [NKEYS];
  logic [RPT_W-1:0] rpt_cnt_d [NKEYS];
  logic [NKEYS-1:0] rpt_phase_q, rpt_phase_d;
  logic [RPT_W-1:0] rpt_next;
  logic [RPT_W-1:0] rpt_limit;
`endif

  assign key_idx = KEY_W'(int'(row_idx_q) * COLS + int'(col_idx_q));
  assign cur_raw = raw_q[row_idx_q];

  // Column drive is forced inactive while reset is held so the matrix idles.
  assign column = reset ? '1 : ~(COLS'(1) << col_idx_q);

  // Scan sequencer: dwell on a column, sample the rows, walk the rows, advance.
  always_comb begin
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    raw_d       = raw_q;
    case (state_q)
      ST_DWELL: begin
        if (dwell_cnt_q == DW'(DWELL_LAST)) begin
          dwell_cnt_d = '0;
          state_d     = ST_SAMPLE;
        end else begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        raw_d     = ~row;
        row_idx_d = '0;
        state_d   = ST_EMIT;
      end
      ST_EMIT: begin
        if (row_idx_q == RW'(ROWS - 1)) begin
          state_d = ST_ADVANCE;
        end else begin
          row_idx_d = row_idx_q + 1'b1;
        end
      end
      ST_ADVANCE: begin
        col_idx_d = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
        state_d   = ST_DWELL;
      end
      default: state_d = ST_DWELL;
    endcase
  end

  // Per-key debounce and event generation, one key per EMIT cycle.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    toggle    = 1'b0;
    ev_push   = 1'b0;
    ev_data   = '0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_next    = rpt_cnt_q[key_idx] + 1'b1;
    rpt_limit   = rpt_phase_q[key_idx] ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);
`endif
    if (state_q == ST_EMIT) begin
      if (cur_raw != stable_q[key_idx]) begin
        if (deb_cnt_q[key_idx] == 4'(DEBOUNCE_SCANS - 1)) begin
          toggle             = 1'b1;
          stable_d[key_idx]  = cur_raw;
          deb_cnt_d[key_idx] = '0;
          ev_push            = 1'b1;
          ev_data            = {key_idx, cur_raw ? EV_PRESS : EV_RELEASE};
        end else begin
          deb_cnt_d[key_idx] = deb_cnt_q[key_idx] + 1'b1;
        end
      end else begin
        deb_cnt_d[key_idx] = '0;
      end
`ifdef KEYPAD_REPEAT_EN
      if (toggle || !stable_q[key_idx]) begin
        rpt_cnt_d[key_idx]   = '0;
        rpt_phase_d[key_idx] = 1'b0;
      end else if (rpt_next == rpt_limit) begin
        rpt_cnt_d[key_idx]   = '0;
        rpt_phase_d[key_idx] = 1'b1;
        ev_push              = 1'b1;
        ev_data              = {key_idx, EV_PRESS};
      end else begin
        rpt_cnt_d[key_idx] = rpt_next;
      end
`endif
    end
  end

  // Overflow is sticky: set whenever an event is pushed but cannot be stored.
  always_comb begin
    overflow_d = overflow_q | (ev_push & fifo_full & ~ev_pop);
  end

  // State registers; reset forgets every key so held keys re-debounce as presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_DWELL;
      dwell_cnt_q <= '0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      raw_q       <= '0;
      stable_q    <= '0;
      deb_cnt_q   <= '{default: '0};
      overflow_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q   <= '{default: '0};
      rpt_phase_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      raw_q       <= raw_d;
      stable_q    <= stable_d;
      deb_cnt_q   <= deb_cnt_d;
      overflow_q  <= overflow_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
`endif
    end
  end

  key_fifo #(
    .WIDTH (KEY_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ev_push),
    .push_data (ev_data),
    .pop       (ev_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign key_valid   = !fifo_empty && !reset;
  assign ev_pop      = key_valid && key_ready;
  assign key_code    = key_valid ? fifo_head[KEY_W:1] : '0;
  assign key_release = key_valid ? fifo_head[0] : 1'b0;
  assign overflow    = overflow_q && !reset;

endmodule
